// File: rtl/demux1to4_reg.sv
// Routes one upstream word per cycle to one of four registered output slots, each with a per-channel delivery counter.
// Latency: 1 cycle from acceptance to y/out_valid; a full slot draining while refilled passes words back-to-back.
// Backpressure: in_ready follows only the selected slot (empty, or draining this cycle), so a stalled channel blocks only its own traffic.
module demux1to4_reg #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          sel,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*DATA_W-1:0] y,
    output logic [31:0]         cnt
);

    logic [3:0] load;
    logic [3:0] deliver;

    // A slot can take a new word if it is empty or its current word leaves on this edge.
    assign in_ready = ~out_valid[sel] | out_ready[sel];
    assign deliver  = out_valid & out_ready;

    always_comb begin
        load = '0;
        if (in_valid && in_ready) begin
            load[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            y         <= '0;
            cnt       <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    y[k*DATA_W +: DATA_W] <= in_data;
                    out_valid[k]          <= 1'b1;
                end else if (deliver[k]) begin
                    out_valid[k] <= 1'b0;
                end
                if (deliver[k]) begin
                    cnt[k*8 +: 8] <= cnt[k*8 +: 8] + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux1to4_reg.sv
// Directed bench for demux1to4_reg: a per-channel one-deep queue model checked every cycle, plus literal checkpoints.
module tb_demux1to4_reg;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [1:0]   sel = '0;
    logic [3:0]   out_ready = '0;
    logic         in_ready;
    logic [3:0]   out_valid;
    logic [4*W-1:0] y;
    logic [31:0]  cnt;

    int n_cmp = 0;
    int n_fail = 0;

    demux1to4_reg #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .cnt(cnt)
    );

    always #5 clk = ~clk;

    // Model: each channel is a queue holding at most one word; counts are plain integers.
    logic [W-1:0] mq [4][$];
    logic [W-1:0] m_last [4] = '{default: '0};
    int           m_dlv  [4] = '{default: 0};

    function automatic logic m_rdy(input logic [1:0] s);
        return (mq[s].size() == 0) || out_ready[s];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin : model
        bit acc;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                m_last[k] <= '0;
                m_dlv[k]  <= 0;
            end
        end else begin
            acc = in_valid && m_rdy(sel);
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0 && out_ready[k]) begin
                    void'(mq[k].pop_front());
                    m_dlv[k] <= m_dlv[k] + 1;
                end
            end
            if (acc) begin
                mq[sel].push_back(in_data);
                m_last[sel] <= in_data;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cyc_valid%0d", k), 32'(out_valid[k]), 32'(mq[k].size() != 0));
            chk($sformatf("cyc_y%0d", k), 32'(y[k*W +: W]), 32'(m_last[k]));
            chk($sformatf("cyc_cnt%0d", k), 32'(cnt[k*8 +: 8]), 32'(m_dlv[k] % 256));
        end
        chk("cyc_in_ready", 32'(in_ready), 32'(m_rdy(sel)));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        sel      = s;
        in_data  = d;
        while (!m_rdy(s) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_cnt", cnt, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        tick();
        rst = 1'b0;

        // Basic routing
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            send(2'(k), 8'hA0 + 8'(k));
            chk("route_valid", 32'(out_valid), 32'(4'b0001 << k));
            chk("route_y", 32'(y[k*W +: W]), 32'(8'hA0 + 8'(k)));
        end
        tick();
        chk("route_cnt", cnt, 32'h01010101);
        chk("route_idle", 32'(out_valid), 32'h0);

        // Stall on channel 2
        out_ready = 4'b1011;
        send(2'd2, 8'h55);
        chk("stall_hold_v", 32'(out_valid[2]), 32'h1);
        chk("stall_hold_y", 32'(y[2*W +: W]), 32'h55);
        in_valid = 1'b1; sel = 2'd2; in_data = 8'h66;
        #1;
        chk("stall_blocked", 32'(in_ready), 32'h0);
        tick(); tick();
        chk("stall_still_blocked", 32'(in_ready), 32'h0);
        chk("stall_still_y", 32'(y[2*W +: W]), 32'h55);
        out_ready[2] = 1'b1;
        #1;
        chk("stall_released", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("stall_next_y", 32'(y[2*W +: W]), 32'h66);
        chk("stall_next_v", 32'(out_valid[2]), 32'h1);
        chk("stall_cnt_a", 32'(cnt[23:16]), 32'h02);
        tick();
        chk("stall_cnt_b", 32'(cnt[23:16]), 32'h03);
        chk("stall_drained", 32'(out_valid[2]), 32'h0);

        // Isolation: channel 1 stalled while channel 3 streams
        out_ready = 4'b1101;
        send(2'd1, 8'h77);
        for (int i = 1; i <= 3; i++) begin
            send(2'd3, 8'(i));
            chk("iso_y1", 32'(y[1*W +: W]), 32'h77);
            chk("iso_v1", 32'(out_valid[1]), 32'h1);
            chk("iso_y3", 32'(y[3*W +: W]), 32'(i));
        end
        tick();
        chk("iso_cnt3", 32'(cnt[31:24]), 32'h04);
        chk("iso_cnt1", 32'(cnt[15:8]), 32'h01);
        out_ready = 4'b1111;
        tick();

        // Fill/drain on channel 0
        do_reset();
        out_ready = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            send(2'd0, 8'h10 + 8'(i));
            chk("fill_v0", 32'(out_valid[0]), 32'h1);
            chk("fill_in_ready", 32'(in_ready), 32'h1);
        end
        tick();
        chk("fill_cnt0", 32'(cnt[7:0]), 32'h0A);
        chk("fill_drained", 32'(out_valid[0]), 32'h0);

        // Counter wrap on channel 1
        do_reset();
        out_ready = 4'b1111;
        for (int i = 1; i <= 257; i++) begin
            send(2'd1, 8'(i));
            if (i == 256) chk("wrap_ff", 32'(cnt[15:8]), 32'hFF);
            if (i == 257) chk("wrap_00", 32'(cnt[15:8]), 32'h00);
        end
        tick();
        chk("wrap_01", 32'(cnt[15:8]), 32'h01);

        // Mid-operation reset with all slots full
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) send(2'(k), 8'hC0 + 8'(k));
        chk("mid_full", 32'(out_valid), 32'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(out_valid), 32'h0);
        chk("mid_y", 32'(y), 32'h0);
        chk("mid_cnt", cnt, 32'h0);
        chk("mid_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        out_ready = 4'b1111;
        tick(); tick(); tick();
        chk("mid_after_valid", 32'(out_valid), 32'h0);
        chk("mid_after_cnt", cnt, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/demux1to4_reg.md
DEMUX1TO4_REG -- requirements
Module: demux1to4_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the upstream word is present.
REQ-005 SHALL have port in_ready, output, 1, meaning the selected channel can accept this cycle.
REQ-006 SHALL have port in_data, input, DATA_W, the upstream payload.
REQ-007 SHALL have port sel, input, 2, the destination channel index 0..3, qualified by in_valid.
REQ-008 SHALL have port out_valid, output, 4, one valid bit per channel, bit k for channel k.
REQ-009 SHALL have port out_ready, input, 4, one ready bit per channel, bit k for channel k.
REQ-010 SHALL have port y, output, 4*DATA_W, channel k payload in bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port cnt, output, 32, an 8-bit delivered-word counter for channel k in bits [k*8 +: 8].

Function
REQ-012 SHALL hold one register slot per channel: data_k (DATA_W) and out_valid[k].
REQ-013 SHALL drive in_ready combinationally as ~out_valid[sel] | out_ready[sel], independent of in_valid.
REQ-014 SHALL accept a word when in_valid & in_ready are both high at a rising edge.
REQ-015 SHALL load in_data into data_sel on acceptance and set out_valid[sel]; the word is visible on y one cycle after acceptance (latency 1).
REQ-016 SHALL count a delivery on channel k when out_valid[k] & out_ready[k] are both high at a rising edge.
REQ-017 SHALL clear out_valid[k] on a delivery unless a new word is accepted for channel k on the same edge.
REQ-018 SHALL, on simultaneous delivery and acceptance for the same channel, replace data_k with the new word, keep out_valid[k] at 1, and count both events (no bubble).
REQ-019 SHALL hold data_k and out_valid[k] stable while out_valid[k]=1 and out_ready[k]=0; no overwrite, no loss.
REQ-020 SHALL let a stalled channel block only words addressed to it; other channels keep accepting and delivering.
REQ-021 SHALL ignore sel and in_data when in_valid=0; no state changes from the input side.
REQ-022 SHALL ignore out_ready[k] when out_valid[k]=0; no count change.
REQ-023 SHALL increment cnt_k by 1 per delivery on channel k, modulo 256 (255 -> 0 wraps silently).
REQ-024 SHALL leave y bits of an empty channel at their last value; consumers qualify y with out_valid.
REQ-025 SHALL support at most one acceptance per cycle and up to four deliveries per cycle, one per channel.

Reset
REQ-026 SHALL, while rst=1, force out_valid=4'b0000, y=0, and cnt=0 immediately, independent of clk.
REQ-027 SHALL drive in_ready from the reset state during reset, so in_ready=1 for any sel, and SHALL accept nothing until the first rising edge after rst deasserts.
REQ-028 SHALL discard any words held in slots when reset is asserted mid-operation; held words are not delivered.

Verification
REQ-029 SHALL pass the basic routing test: after reset, out_ready=4'b1111; send in_data=8'hA0..8'hA3 with sel=0..3 on consecutive cycles. Each word appears on the correct y slice one cycle later with only that out_valid bit set, and cnt ends at 8'h01 per channel.
REQ-030 SHALL pass the stall test: out_ready[2]=0; send 8'h55 with sel=2, then 8'h66 with sel=2. The first word is held, and in_ready=0 on the second word until out_ready[2]=1. 8'h55 is then delivered, followed by 8'h66 on the next cycle, and cnt_2 increments by 2.
REQ-031 SHALL pass the isolation test: channel 1 is stalled with a word held; sel=3 words 8'h01, 8'h02, 8'h03 are delivered back-to-back on channel 3. Channel 1 data and out_valid[1] stay unchanged throughout.
REQ-032 SHALL pass the fill/drain test: with out_ready[0]=1, stream 10 consecutive words with sel=0. in_ready stays 1, out_valid[0] stays 1 from cycle 2 to cycle 11, and cnt_0 ends at 8'h0A.
REQ-033 SHALL pass the wrap test: deliver 257 words on channel 1. cnt_1 reads 8'hFF after 255 words, 8'h00 after 256 words, and 8'h01 after 257 words.
REQ-034 SHALL pass the mid-operation reset test: with all four slots full and out_ready=0, pulse rst between clock edges. out_valid=0, y=0, and cnt=0 immediately, and no held word is delivered afterwards.
